// File: rtl/store_beat_packer.sv
// store_beat_packer: aligns sub-word writes into 64-bit beats with byte masks,
// merges consecutive writes to the same beat index, and presents finished
// beats through a one-entry registered output slot (ready/valid).
// Optional feature macro: MERGE_TIMEOUT_EN. When it is defined, an idle
// counter force-emits a held beat after TIMEOUT_CYCLES cycles without an accept.
//
// Accumulator states:
//   state      | meaning
//   ACC_EMPTY  | no beat held
//   ACC_OPEN   | beat held, further same-index writes merge into it
//   ACC_CLOSED | beat complete (last/flush/timeout), waiting for the output slot
module store_beat_packer #(
   parameter int BEAT_W         = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_in_valid,
   output logic              io_in_ready,
   input  logic [BEAT_W-1:0] io_in_bits_beat,
   input  logic [2:0]        io_in_bits_addr,
   input  logic [1:0]        io_in_bits_size,
   input  logic [63:0]       io_in_bits_data,
   input  logic              io_in_bits_last,
   input  logic              io_flush,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [7:0]        io_out_bits_mask,
   output logic [63:0]       io_out_bits_data,
   output logic              io_misaligned
);

   if (TIMEOUT_CYCLES < 1 || BEAT_W < 1) begin : g_param_check
      $error("store_beat_packer: BEAT_W and TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      ACC_EMPTY  = 2'd0,
      ACC_OPEN   = 2'd1,
      ACC_CLOSED = 2'd2
   } acc_state_t;

   acc_state_t        r_acc_state;
   acc_state_t        w_acc_state_nxt;
   logic [BEAT_W-1:0] r_acc_beat;
   logic [7:0]        r_acc_mask;
   logic [63:0]       r_acc_data;
   logic [BEAT_W-1:0] w_acc_beat_nxt;
   logic [7:0]        w_acc_mask_nxt;
   logic [63:0]       w_acc_data_nxt;

   logic              r_out_valid;
   logic [7:0]        r_out_mask;
   logic [63:0]       r_out_data;
   logic              w_slot_load;
   logic [7:0]        w_slot_mask;
   logic [63:0]       w_slot_data;

   logic              r_misaligned;

   logic [2:0]        w_eff_addr;
   logic [7:0]        w_size_mask;
   logic [7:0]        w_in_mask;
   logic [63:0]       w_in_lane;
   logic [63:0]       w_in_bytes;
   logic [63:0]       w_new_data;
   logic [63:0]       w_merge_data;
   logic [7:0]        w_merge_mask;
   logic              w_misalign;
   logic              w_accept;
   logic              w_slot_free;
   logic              w_same_beat;
   logic              w_close_in;
   logic              w_tmo;

   // Alignment: drop low address bits below the access size, build the byte
   // mask and shift the LSB-justified data into its lane.
   always_comb begin
      w_eff_addr  = io_in_bits_addr;
      w_size_mask = 8'h01;
      case (io_in_bits_size)
         2'd0: begin w_eff_addr = io_in_bits_addr;                w_size_mask = 8'h01; end
         2'd1: begin w_eff_addr = io_in_bits_addr & 3'b110;       w_size_mask = 8'h03; end
         2'd2: begin w_eff_addr = io_in_bits_addr & 3'b100;       w_size_mask = 8'h0F; end
         default: begin w_eff_addr = 3'b000;                      w_size_mask = 8'hFF; end
      endcase
   end

   assign w_in_mask  = w_size_mask << w_eff_addr;
   assign w_in_lane  = io_in_bits_data << {w_eff_addr, 3'b000};
   assign w_misalign = (io_in_bits_addr != w_eff_addr);

   for (genvar gi = 0; gi < 8; gi++) begin : g_byte_en
      assign w_in_bytes[8*gi +: 8] = {8{w_in_mask[gi]}};
   end

   // Bytes outside the write mask are zeroed so unwritten lanes never carry stale data.
   assign w_new_data   = w_in_lane & w_in_bytes;
   assign w_merge_data = (r_acc_data & ~w_in_bytes) | w_new_data;
   assign w_merge_mask = r_acc_mask | w_in_mask;

   assign w_slot_free = ~r_out_valid | io_out_ready;
   assign io_in_ready = (r_acc_state == ACC_EMPTY) | ~r_out_valid | io_out_ready;
   assign w_accept    = io_in_valid & io_in_ready;
   assign w_same_beat = (r_acc_state == ACC_OPEN) && (r_acc_beat == io_in_bits_beat);
   assign w_close_in  = io_in_bits_last | io_flush;

`ifdef MERGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_tmo_cnt;

   assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

   // Idle counter: restarts on any accept or when nothing is held, saturates at the limit.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tmo_cnt <= '0;
      end else if (w_accept || r_acc_state == ACC_EMPTY) begin
         r_tmo_cnt <= '0;
      end else if (!w_tmo) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   // Next accumulator state and what (if anything) moves into the output slot.
   // An accept while a beat is held implies the slot is free this cycle.
   always_comb begin
      w_acc_state_nxt = r_acc_state;
      w_acc_beat_nxt  = r_acc_beat;
      w_acc_mask_nxt  = r_acc_mask;
      w_acc_data_nxt  = r_acc_data;
      w_slot_load     = 1'b0;
      w_slot_mask     = r_acc_mask;
      w_slot_data     = r_acc_data;
      case (r_acc_state)
         ACC_EMPTY: begin
            if (w_accept) begin
               if (w_close_in && w_slot_free) begin
                  w_slot_load = 1'b1;
                  w_slot_mask = w_in_mask;
                  w_slot_data = w_new_data;
               end else begin
                  w_acc_beat_nxt  = io_in_bits_beat;
                  w_acc_mask_nxt  = w_in_mask;
                  w_acc_data_nxt  = w_new_data;
                  w_acc_state_nxt = w_close_in ? ACC_CLOSED : ACC_OPEN;
               end
            end
         end
         ACC_OPEN: begin
            if (w_accept && w_same_beat) begin
               if (w_close_in) begin
                  w_slot_load     = 1'b1;
                  w_slot_mask     = w_merge_mask;
                  w_slot_data     = w_merge_data;
                  w_acc_state_nxt = ACC_EMPTY;
               end else begin
                  w_acc_mask_nxt = w_merge_mask;
                  w_acc_data_nxt = w_merge_data;
               end
            end else if (w_accept) begin
               // Different beat: old beat leaves; a flush this cycle only closes the old one.
               w_slot_load     = 1'b1;
               w_acc_beat_nxt  = io_in_bits_beat;
               w_acc_mask_nxt  = w_in_mask;
               w_acc_data_nxt  = w_new_data;
               w_acc_state_nxt = io_in_bits_last ? ACC_CLOSED : ACC_OPEN;
            end else if (io_flush || w_tmo) begin
               if (w_slot_free) begin
                  w_slot_load     = 1'b1;
                  w_acc_state_nxt = ACC_EMPTY;
               end else begin
                  w_acc_state_nxt = ACC_CLOSED;
               end
            end
         end
         ACC_CLOSED: begin
            if (w_slot_free) begin
               w_slot_load = 1'b1;
               if (w_accept) begin
                  w_acc_beat_nxt  = io_in_bits_beat;
                  w_acc_mask_nxt  = w_in_mask;
                  w_acc_data_nxt  = w_new_data;
                  w_acc_state_nxt = w_close_in ? ACC_CLOSED : ACC_OPEN;
               end else begin
                  w_acc_state_nxt = ACC_EMPTY;
               end
            end
         end
         default: w_acc_state_nxt = ACC_EMPTY;
      endcase
   end

   // Accumulator registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc_state <= ACC_EMPTY;
         r_acc_beat  <= '0;
         r_acc_mask  <= '0;
         r_acc_data  <= '0;
      end else begin
         r_acc_state <= w_acc_state_nxt;
         r_acc_beat  <= w_acc_beat_nxt;
         r_acc_mask  <= w_acc_mask_nxt;
         r_acc_data  <= w_acc_data_nxt;
      end
   end

   // Output slot: reload wins over drain so a freed slot refills in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_mask  <= '0;
         r_out_data  <= '0;
      end else if (w_slot_load) begin
         r_out_valid <= 1'b1;
         r_out_mask  <= w_slot_mask;
         r_out_data  <= w_slot_data;
      end else if (io_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Sticky misalignment flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_misaligned <= 1'b0;
      end else if (w_accept && w_misalign) begin
         r_misaligned <= 1'b1;
      end
   end

   assign io_out_valid     = r_out_valid;
   assign io_out_bits_mask = r_out_mask;
   assign io_out_bits_data = r_out_data;
   assign io_misaligned    = r_misaligned;

endmodule
